// File: rtl/counter_sequencer.sv
// Purpose : control FSM plus WIDTH-bit up/down count register; sequences q from a
//           latched start value to a latched terminal value with pause/stop/restart.
// Latency : start accepted at edge n -> q=ld_val after n, first step at n+1;
//           done is a registered one-cycle pulse in the first DONE cycle.
// Backpres: none; pause freezes q, stop returns to IDLE holding q, start is
//           ignored while busy.
//
// Ports:
//   clk       in   1      rising-edge clock
//   clr       in   1      asynchronous reset, active-high (q, state, latches, done -> 0)
//   start     in   1      level; accepted in IDLE/DONE: loads q, latches operands, enters RUN
//   pause     in   1      level; RUN -> PAUSE while high, PAUSE -> RUN when low
//   stop      in   1      level; any state -> IDLE, q holds (highest priority)
//   dir       in   1      1 = count up, 0 = count down (latched on accepted start)
//   ld_val    in   WIDTH  start value (latched on accepted start)
//   term_val  in   WIDTH  terminal value (latched on accepted start)
//   q         out  WIDTH  current count (registered)
//   busy      out  1      state is RUN or PAUSE
//   done      out  1      one-cycle completion pulse (registered)
//   state     out  2      00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//
// Build option: COUNTER_SEQUENCER_AUTO_RELOAD_EN -- when defined, reaching the
// terminal count in RUN reloads the latched start value and stays in RUN, pulsing
// done once per period; DONE is then unreachable.

module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             dir,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q,  term_d;
  logic             dir_q,   dir_d;
  logic             done_q,  done_d;
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
  // The start value only needs to be kept when it is re-used at every period end.
  logic [WIDTH-1:0] ld_q,    ld_d;
`endif

  logic             accept_start;
  logic             run_active;
  logic             at_term;
  logic [WIDTH-1:0] step_val;

  // start counts only in IDLE/DONE and loses to stop on the same edge.
  assign accept_start = start && !stop &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // RUN cycle that is neither stopped nor paused: terminal check or step.
  assign run_active   = (state_q == ST_RUN) && !stop && !pause;
  assign at_term      = (count_q == term_q);
  // Natural modulo-2^WIDTH wrap in both directions.
  assign step_val     = dir_q ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      term_q  <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
      ld_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
      ld_q    <= ld_d;
`endif
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop)         state_d = ST_IDLE;
        else if (pause)   state_d = ST_PAUSE;
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
        else              state_d = ST_RUN;
`else
        else if (at_term) state_d = ST_DONE;
`endif
      end
      ST_PAUSE: begin
        if (stop)         state_d = ST_IDLE;
        else if (!pause)  state_d = ST_RUN;
      end
      ST_DONE: begin
        if (stop)              state_d = ST_IDLE;
        else if (accept_start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    count_d = count_q;
    term_d  = term_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
    ld_d    = ld_q;
`endif
    if (accept_start) begin
      count_d = ld_val;
      term_d  = term_val;
      dir_d   = dir;
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
      ld_d    = ld_val;
`endif
    end else if (run_active) begin
      if (at_term) begin
        // Terminal is seen one edge after q reaches it, so done lands in the
        // first cycle of DONE (or of the reloaded period).
        done_d  = 1'b1;
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
        count_d = ld_q;
`endif
      end else begin
        count_d = step_val;
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    state = state_q;
    q     = count_q;
    done  = done_q;
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Purpose : directed table-driven check of counter_sequencer plus hand sequences
//           for async clear mid-run, ld==term, and the auto-reload build option.
// Compile with the same COUNTER_SEQUENCER_AUTO_RELOAD_EN setting as the RTL.
module tb_counter_sequencer;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic       clk = 1'b0;
  logic       clr;
  logic       start, pause, stop, dir;
  logic [3:0] ld_val, term_val;
  logic [3:0] q;
  logic       busy, done;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  counter_sequencer #(.WIDTH(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .dir      (dir),
    .ld_val   (ld_val),
    .term_val (term_val),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       pause;
    logic       stop;
    logic       dir;
    logic [3:0] ld;
    logic [3:0] term;
    logic [3:0] q;
    logic [1:0] st;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic s, input logic p, input logic sp, input logic d,
                             input logic [3:0] l, input logic [3:0] t,
                             input logic [3:0] eq, input logic [1:0] est,
                             input logic eb, input logic ed);
    vec_t r;
    r.start = s;  r.pause = p;  r.stop = sp; r.dir = d;
    r.ld    = l;  r.term  = t;
    r.q     = eq; r.st    = est; r.busy = eb; r.done = ed;
    return r;
  endfunction

  // Cycle with no control asserted; operands are randomised at apply time.
  function automatic vec_t n(input logic [3:0] eq, input logic [1:0] est,
                             input logic eb, input logic ed);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, eq, est, eb, ed);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic [1:0] est,
                         input logic eb, input logic ed);
    chk({tag, " q"},     32'(q),     32'(eq));
    chk({tag, " state"}, 32'(state), 32'(est));
    chk({tag, " busy"},  32'(busy),  32'(eb));
    chk({tag, " done"},  32'(done),  32'(ed));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; dir = 1'b0;
    ld_val = 4'h0; term_val = 4'h0;

    // Reset: outputs idle while clr is held and after release, before any start.
    #12;
    chk_all("reset_held", 4'd0, S_IDLE, 1'b0, 1'b0);
    #8;
    clr = 1'b0;
    #1;
    chk_all("reset_rel", 4'd0, S_IDLE, 1'b0, 1'b0);
    tick();
    chk_all("idle_hold", 4'd0, S_IDLE, 1'b0, 1'b0);

`ifndef COUNTER_SEQUENCER_AUTO_RELOAD_EN
    // up 3 -> 7, operands/dir scrambled after start must not matter
    vecs.push_back(v(1,0,0,1, 4'd3, 4'd7,  4'd3, S_RUN, 1, 0));
    vecs.push_back(n(4'd4, S_RUN, 1, 0));
    vecs.push_back(n(4'd5, S_RUN, 1, 0));
    vecs.push_back(n(4'd6, S_RUN, 1, 0));
    vecs.push_back(n(4'd7, S_RUN, 1, 0));
    vecs.push_back(n(4'd7, S_DONE, 0, 1));
    vecs.push_back(n(4'd7, S_DONE, 0, 0));
    vecs.push_back(n(4'd7, S_DONE, 0, 0));
    // restart from DONE: down 1 -> 14 wrapping through 0
    vecs.push_back(v(1,0,0,0, 4'd1, 4'd14, 4'd1,  S_RUN, 1, 0));
    vecs.push_back(n(4'd0,  S_RUN, 1, 0));
    vecs.push_back(n(4'd15, S_RUN, 1, 0));
    vecs.push_back(n(4'd14, S_RUN, 1, 0));
    vecs.push_back(n(4'd14, S_DONE, 0, 1));
    vecs.push_back(n(4'd14, S_DONE, 0, 0));
    vecs.push_back(v(0,0,1,0, 4'd0, 4'd0,  4'd14, S_IDLE, 0, 0));
    vecs.push_back(n(4'd14, S_IDLE, 0, 0));
    // up wrap 14 -> 1
    vecs.push_back(v(1,0,0,1, 4'd14, 4'd1, 4'd14, S_RUN, 1, 0));
    vecs.push_back(n(4'd15, S_RUN, 1, 0));
    vecs.push_back(n(4'd0,  S_RUN, 1, 0));
    vecs.push_back(n(4'd1,  S_RUN, 1, 0));
    vecs.push_back(n(4'd1,  S_DONE, 0, 1));
    // up 0 -> 9 with start ignored in RUN and a 3-cycle pause at q=4
    vecs.push_back(v(1,0,0,1, 4'd0, 4'd9,  4'd0, S_RUN, 1, 0));
    vecs.push_back(n(4'd1, S_RUN, 1, 0));
    vecs.push_back(v(1,0,0,0, 4'd7, 4'd7,  4'd2, S_RUN, 1, 0));
    vecs.push_back(n(4'd3, S_RUN, 1, 0));
    vecs.push_back(n(4'd4, S_RUN, 1, 0));
    vecs.push_back(v(0,1,0,0, 4'd0, 4'd0,  4'd4, S_PAUSE, 1, 0));
    vecs.push_back(v(0,1,0,0, 4'd0, 4'd0,  4'd4, S_PAUSE, 1, 0));
    vecs.push_back(v(0,1,0,0, 4'd0, 4'd0,  4'd4, S_PAUSE, 1, 0));
    vecs.push_back(n(4'd4, S_RUN, 1, 0));
    vecs.push_back(n(4'd5, S_RUN, 1, 0));
    vecs.push_back(n(4'd6, S_RUN, 1, 0));
    vecs.push_back(n(4'd7, S_RUN, 1, 0));
    vecs.push_back(n(4'd8, S_RUN, 1, 0));
    vecs.push_back(n(4'd9, S_RUN, 1, 0));
    vecs.push_back(n(4'd9, S_DONE, 0, 1));
    // stop beats start in DONE
    vecs.push_back(v(1,0,1,1, 4'd3, 4'd3,  4'd9, S_IDLE, 0, 0));
    // up 2 -> 12, stop at 6, start+stop in IDLE ignored, restart
    vecs.push_back(v(1,0,0,1, 4'd2, 4'd12, 4'd2, S_RUN, 1, 0));
    vecs.push_back(n(4'd3, S_RUN, 1, 0));
    vecs.push_back(n(4'd4, S_RUN, 1, 0));
    vecs.push_back(n(4'd5, S_RUN, 1, 0));
    vecs.push_back(n(4'd6, S_RUN, 1, 0));
    vecs.push_back(v(0,0,1,0, 4'd0, 4'd0,  4'd6, S_IDLE, 0, 0));
    vecs.push_back(n(4'd6, S_IDLE, 0, 0));
    vecs.push_back(v(1,0,1,1, 4'd2, 4'd12, 4'd6, S_IDLE, 0, 0));
    vecs.push_back(v(1,0,0,1, 4'd2, 4'd12, 4'd2, S_RUN, 1, 0));
    vecs.push_back(n(4'd3, S_RUN, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start;
      pause = vecs[i].pause;
      stop  = vecs[i].stop;
      if (vecs[i].start) begin
        dir = vecs[i].dir; ld_val = vecs[i].ld; term_val = vecs[i].term;
      end else begin
        dir = 1'($urandom); ld_val = 4'($urandom); term_val = 4'($urandom);
      end
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].st, vecs[i].busy, vecs[i].done);
    end
    start = 1'b0; pause = 1'b0; stop = 1'b0;

    // clr mid-run takes effect without waiting for a clock edge
    #2;
    clr = 1'b1;
    #1;
    chk_all("clr_async", 4'd0, S_IDLE, 1'b0, 1'b0);
    start = 1'b1; dir = 1'b1; ld_val = 4'd9; term_val = 4'd11;
    tick();
    chk_all("clr_held", 4'd0, S_IDLE, 1'b0, 1'b0);
    clr = 1'b0; start = 1'b0;

    // ld == term: DONE one edge after start, no step taken
    start = 1'b1; dir = 1'b1; ld_val = 4'd5; term_val = 4'd5;
    tick();
    chk_all("eq_start", 4'd5, S_RUN, 1'b1, 1'b0);
    start = 1'b0; ld_val = 4'd0; term_val = 4'd0;
    tick();
    chk_all("eq_done", 4'd5, S_DONE, 1'b0, 1'b1);
    tick();
    chk_all("eq_hold", 4'd5, S_DONE, 1'b0, 1'b0);
`else
    // auto-reload: 2 -> 4 up repeats with a 3-cycle period, done at each reload
    start = 1'b1; dir = 1'b1; ld_val = 4'd2; term_val = 4'd4;
    tick();
    chk_all("ar_start", 4'd2, S_RUN, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      dir = 1'($urandom); ld_val = 4'($urandom); term_val = 4'($urandom);
      tick();
      chk_all($sformatf("ar%0d", k), 4'(2 + (k % 3)), S_RUN, 1'b1, (k % 3) == 0);
    end
    #2;
    clr = 1'b1;
    #1;
    chk_all("clr_async", 4'd0, S_IDLE, 1'b0, 1'b0);
    clr = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: the stimulus is fixed-length, so this only fires on a stall.
  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
